// File: rtl/ilvds_deser_pkg.sv
// Shared definitions for the differential-serial deserializer:
// FSM encoding, alignment defaults and a small saturating helper.
package ilvds_deser_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam logic [7:0]  SYNC_PAT_DEF = 8'hA5;
   localparam int unsigned SYNC_CNT_DEF = 2;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ilvds_deser_if.sv
// Serial-in / word-out signal bundle of the deserializer, for benches and
// surrounding glue that want to pass the whole port group around at once.
interface ilvds_deser_if;
   logic       EN;
   logic       A;
   logic       AN;
   logic [7:0] Q;
   logic       QV;
   logic       LOCK;
   logic       DERR;
   logic [7:0] ERRCNT;

   modport master (output EN, A, AN, input Q, QV, LOCK, DERR, ERRCNT);
   modport slave  (input EN, A, AN, output Q, QV, LOCK, DERR, ERRCNT);
endinterface

// File: rtl/ilvds_deser.sv
// Differential serial-to-parallel converter: hunts for SYNC_PAT, confirms
// SYNC_CNT aligned words, then emits each following byte MSB-first with a QV strobe.
module ilvds_deser
   import ilvds_deser_pkg::*;
#(
   parameter logic [7:0]  SYNC_PAT = SYNC_PAT_DEF,
   parameter int unsigned SYNC_CNT = SYNC_CNT_DEF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic       A,
   input  logic       AN,
   output logic [7:0] Q,
   output logic       QV,
   output logic       LOCK,
   output logic       DERR,
   output logic [7:0] ERRCNT
);

   localparam logic [3:0] SYNC_CNT_L = 4'(SYNC_CNT);

   state_e     state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [7:0] q_q, q_d;
   logic [7:0] errcnt_q, errcnt_d;
   logic [2:0] bit_q, bit_d;
   logic [3:0] sync_q, sync_d;
   logic       qv_q, qv_d;
   logic       derr_q, derr_d;
   logic       lock_q, lock_d;

   logic       smp_ok, smp_bad, word_end, pat_hit;
   logic [7:0] sr_upd;

   assign smp_ok   = EN & (A ^ AN);
   assign smp_bad  = EN & ~(A ^ AN);
   assign sr_upd   = {sr_q[6:0], A};
   assign word_end = (bit_q == 3'd7);
   assign pat_hit  = (sr_upd == SYNC_PAT);

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_HUNT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (smp_bad) begin
         state_d = ST_HUNT;
      end else if (smp_ok) begin
         case (state_q)
            ST_HUNT:
               if (pat_hit) state_d = (SYNC_CNT_L == 4'd1) ? ST_LOCKED : ST_SYNC;
            ST_SYNC:
               if (word_end) begin
                  if (!pat_hit)                          state_d = ST_HUNT;
                  else if (sync_q + 4'd1 == SYNC_CNT_L)  state_d = ST_LOCKED;
               end
            default: ;
         endcase
      end
   end

   // Bit counter stays parked at 0 while hunting so the first word after the
   // anchor pattern is counted from a clean boundary.
   always_comb begin
      sr_d     = sr_q;
      bit_d    = bit_q;
      sync_d   = sync_q;
      q_d      = q_q;
      qv_d     = 1'b0;
      derr_d   = 1'b0;
      errcnt_d = errcnt_q;
      lock_d   = (state_d == ST_LOCKED);
      if (smp_bad) begin
         derr_d   = 1'b1;
         errcnt_d = sat_inc8(errcnt_q);
         bit_d    = 3'd0;
         sync_d   = 4'd0;
      end else if (smp_ok) begin
         sr_d  = sr_upd;
         bit_d = bit_q + 3'd1;
         case (state_q)
            ST_HUNT: begin
               bit_d  = 3'd0;
               sync_d = pat_hit ? 4'd1 : 4'd0;
            end
            ST_SYNC:
               if (word_end) sync_d = pat_hit ? sync_q + 4'd1 : 4'd0;
            ST_LOCKED:
               if (word_end) begin
                  q_d  = sr_upd;
                  qv_d = 1'b1;
               end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sr_q     <= 8'd0;
         q_q      <= 8'd0;
         errcnt_q <= 8'd0;
         bit_q    <= 3'd0;
         sync_q   <= 4'd0;
         qv_q     <= 1'b0;
         derr_q   <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         q_q      <= q_d;
         errcnt_q <= errcnt_d;
         bit_q    <= bit_d;
         sync_q   <= sync_d;
         qv_q     <= qv_d;
         derr_q   <= derr_d;
         lock_q   <= lock_d;
      end
   end

   assign Q      = q_q;
   assign QV     = qv_q;
   assign LOCK   = lock_q;
   assign DERR   = derr_q;
   assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_ilvds_deser.sv
// Bench for ilvds_deser: byte-level vector table, hand-built corner sequences,
// then a random serial stream scored against a bit-history alignment model.
module tb_ilvds_deser;

   localparam logic [7:0]  PAT  = 8'hA5;
   localparam int unsigned SCNT = 2;

   logic CLK, RST;
   ilvds_deser_if bus ();

   ilvds_deser #(.SYNC_PAT(PAT), .SYNC_CNT(SCNT)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (bus.EN),
      .A     (bus.A),
      .AN    (bus.AN),
      .Q     (bus.Q),
      .QV    (bus.QV),
      .LOCK  (bus.LOCK),
      .DERR  (bus.DERR),
      .ERRCNT(bus.ERRCNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   int qv_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Drive one cycle, then sample 1 time unit after the edge.
   task automatic tick(input logic rst, input logic en, input logic a, input logic an);
      RST    = rst;
      bus.EN = en;
      bus.A  = a;
      bus.AN = an;
      @(posedge CLK);
      #1;
      if (bus.QV === 1'b1) qv_seen++;
   endtask

   task automatic send_bits(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b1, d[7-i], ~d[7-i]);
   endtask

   function automatic logic [18:0] outs();
      return {bus.LOCK, bus.QV, bus.DERR, bus.Q, bus.ERRCNT};
   endfunction

   typedef struct {
      bit         rst;
      logic [7:0] data;
      int         nbits;
      logic       exp_lock;
      logic       exp_qv;
      logic [7:0] exp_q;
   } vec_t;

   function automatic vec_t mk(bit r, logic [7:0] d, int n, logic l, logic v, logic [7:0] q);
      vec_t t;
      t.rst = r; t.data = d; t.nbits = n; t.exp_lock = l; t.exp_qv = v; t.exp_q = q;
      return t;
   endfunction

   // Reference model: remembers whether an anchor pattern was seen and how many
   // good bits followed it; words are judged by position relative to the anchor.
   int m_sr, m_since, m_q, m_err;
   bit m_aligned, m_qv, m_derr;

   function automatic void model_step(bit rst, bit en, bit a, bit an);
      int w;
      m_qv = 0;
      m_derr = 0;
      if (rst) begin
         m_sr = 0; m_since = 0; m_q = 0; m_err = 0; m_aligned = 0;
         return;
      end
      if (!en) return;
      if (a == an) begin
         m_derr = 1;
         if (m_err < 255) m_err++;
         m_aligned = 0;
         m_since = 0;
         return;
      end
      m_sr = (m_sr * 2 + int'(a)) % 256;
      if (!m_aligned) begin
         if (m_sr == int'(PAT)) begin
            m_aligned = 1;
            m_since = 0;
         end
         return;
      end
      m_since++;
      if (m_since % 8 == 0) begin
         w = m_since / 8;
         if (w < int'(SCNT)) begin
            if (m_sr != int'(PAT)) begin
               m_aligned = 0;
               m_since = 0;
            end
         end else begin
            m_qv = 1;
            m_q = m_sr;
         end
      end
   endfunction

   function automatic logic [18:0] model_outs();
      logic l;
      l = m_aligned && (m_since / 8 >= int'(SCNT) - 1);
      return {l, m_qv, m_derr, 8'(m_q), 8'(m_err)};
   endfunction

   vec_t tv[$];
   bit   bq[$];

   initial begin
      RST = 1'b1; bus.EN = 1'b0; bus.A = 1'b0; bus.AN = 1'b1;

      tv.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'hA5, 8, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'hA5, 8, 1, 0, 8'h00));
      tv.push_back(mk(0, 8'h3C, 8, 1, 1, 8'h3C));
      tv.push_back(mk(0, 8'h7E, 8, 1, 1, 8'h7E));
      tv.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'hB0, 4, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'hA5, 8, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'hA5, 8, 1, 0, 8'h00));
      tv.push_back(mk(0, 8'h11, 8, 1, 1, 8'h11));
      tv.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'hA5, 8, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'h5A, 8, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'hA5, 8, 0, 0, 8'h00));
      tv.push_back(mk(0, 8'hA5, 8, 1, 0, 8'h00));
      tv.push_back(mk(0, 8'h3C, 8, 1, 1, 8'h3C));

      foreach (tv[k]) begin
         if (tv[k].rst) begin
            tick(1'b1, 1'b1, 1'b1, 1'b0);
            check($sformatf("vec%0d reset outputs", k), 32'(outs()), 32'd0);
         end else begin
            qv_seen = 0;
            send_bits(tv[k].data, tv[k].nbits - 1);
            check($sformatf("vec%0d early QV", k), qv_seen, 0);
            send_bits(tv[k].data << (tv[k].nbits - 1), 1);
            check($sformatf("vec%0d LOCK", k), 32'(bus.LOCK), 32'(tv[k].exp_lock));
            check($sformatf("vec%0d QV", k), 32'(bus.QV), 32'(tv[k].exp_qv));
            check($sformatf("vec%0d Q", k), 32'(bus.Q), 32'(tv[k].exp_q));
         end
      end

      // Invalid sample mid-word while locked
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      send_bits(8'hA5, 8);
      send_bits(8'hA5, 8);
      check("derr pre LOCK", 32'(bus.LOCK), 32'd1);
      send_bits(8'hF0, 3);
      qv_seen = 0;
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      check("derr DERR", 32'(bus.DERR), 32'd1);
      check("derr LOCK", 32'(bus.LOCK), 32'd0);
      check("derr ERRCNT", 32'(bus.ERRCNT), 32'd1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      check("derr strobe width", 32'(bus.DERR), 32'd0);
      send_bits(8'h00, 5);
      check("derr partial word QV", qv_seen, 0);

      // EN gaps mid-word, then ERRCNT saturation
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      send_bits(8'hA5, 8);
      send_bits(8'hA5, 8);
      send_bits(8'hC3, 4);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b1, 1'b1);
         check($sformatf("engap%0d QV/DERR/LOCK", i), {bus.QV, bus.DERR, bus.LOCK}, 3'b001);
      end
      send_bits(8'h30, 4);
      check("engap QV", 32'(bus.QV), 32'd1);
      check("engap Q", 32'(bus.Q), 32'hC3);
      for (int i = 0; i < 300; i++) begin
         tick(1'b0, 1'b1, i[0], i[0]);
         if (i == 253) check("errcnt 254", 32'(bus.ERRCNT), 32'hFE);
         if (i == 254) check("errcnt 255", 32'(bus.ERRCNT), 32'hFF);
      end
      check("errcnt saturated", 32'(bus.ERRCNT), 32'hFF);

      // Reset mid-word while locked; relock needs two fresh patterns
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      send_bits(8'hA5, 8);
      send_bits(8'hA5, 8);
      send_bits(8'h3C, 8);
      check("rst pre Q", 32'(bus.Q), 32'h3C);
      send_bits(8'h3C, 4);
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      check("rst mid-word outputs", 32'(outs()), 32'd0);
      send_bits(8'h00, 4);
      send_bits(8'hA5, 8);
      check("relock after 1 pattern", 32'(bus.LOCK), 32'd0);
      send_bits(8'hA5, 8);
      check("relock after 2 patterns", 32'(bus.LOCK), 32'd1);

      // Random stream scored cycle by cycle
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      model_step(1, 0, 0, 1);
      for (int c = 0; c < 3000; c++) begin
         bit r, e, a, an;
         r = ($urandom % 300 == 0);
         e = ($urandom % 8 != 0);
         if (bq.size() == 0) begin
            logic [7:0] b;
            b = ($urandom % 2 == 0) ? PAT : 8'($urandom);
            for (int j = 7; j >= 0; j--) bq.push_back(b[j]);
         end
         if (e && !r && ($urandom % 40 == 0)) begin
            a = 1'($urandom);
            an = a;
         end else begin
            a = bq[0];
            an = ~a;
            if (e && !r) void'(bq.pop_front());
         end
         tick(r, e, a, an);
         model_step(r, e, a, an);
         check($sformatf("rand cyc%0d {LOCK,QV,DERR,Q,ERRCNT}", c), 32'(outs()), 32'(model_outs()));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
